// File: rtl/tdsp_pkg.sv
// tdsp_pkg: shared tdsp bus-machine states, default parameters and strobe rule
package tdsp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_ACC, S_HOLD, S_DONE} state_t;
  localparam int DEF_DW = 16;
  localparam int DEF_AW = 8;
  localparam int DEF_NCH = 3;
  localparam int DEF_WAIT = 0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic strobe_ok(input logic a, input logic r, input logic w, input logic h);
    return (int'(a) + int'(r) + int'(w) + int'(h)) <= 1;
  endfunction
endpackage

// File: rtl/tdsp_rr_pick.sv
// tdsp_rr_pick: round-robin winner search starting at rr_ptr, upward with wrap
module tdsp_rr_pick
  import tdsp_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int IW = idx_w(NCH)
) (
  input  logic [NCH-1:0] pending,
  input  logic [IW-1:0]  rr_ptr,
  output logic [NCH-1:0] winner,
  output logic [IW-1:0]  idx
);
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (winner == '0 && pending[(int'(rr_ptr) + k) % NCH]) begin
        winner = NCH'(1) << ((int'(rr_ptr) + k) % NCH);
        idx = IW'((int'(rr_ptr) + k) % NCH);
      end
    end
  end
endmodule

// File: rtl/tdsp_mbus_mach.sv
// tdsp_mbus_mach: shared multi-channel bus machine with round-robin channel arbitration
module tdsp_mbus_mach
  import tdsp_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int NCH = DEF_NCH,
  parameter int WAIT = DEF_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic [NCH-1:0]    ch_go,
  input  logic [NCH-1:0]    ch_read,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_done,
  output logic [DW-1:0]     rdata,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic              as,
  output logic              read,
  output logic              write,
  output logic              write_h,
  output logic [AW-1:0]     address,
  output logic [DW-1:0]     pad_data_out,
  input  logic [DW-1:0]     pad_data_in
);
  localparam int IW = idx_w(NCH);
  state_t state, state_n;
  logic [NCH-1:0] pending, load, s_rd, pick_oh;
  logic [AW-1:0] s_addr [NCH];
  logic [DW-1:0] s_wdata [NCH];
  logic [IW-1:0] rr_ptr, win, pick_idx;
  logic [2:0] cnt;
  logic last, win_rd, busy;
  tdsp_rr_pick #(.NCH(NCH)) u_pick (.pending(pending), .rr_ptr(rr_ptr), .winner(pick_oh), .idx(pick_idx));
  // a go during the done pulse re-arms the slot; otherwise a pending slot is frozen
  assign load = ch_go & (~pending | ch_done);
  always_comb begin
    last = cnt == 3'(WAIT);
    win_rd = s_rd[win];
    busy = state inside {S_ADDR, S_ACC, S_HOLD};
    state_n = state == S_IDLE ? (sync && |pick_oh ? S_REQ : S_IDLE)
            : state == S_REQ  ? (bus_grant ? S_ADDR : S_REQ)
            : state == S_ADDR ? S_ACC
            : state == S_ACC  ? (!last ? S_ACC : win_rd ? S_DONE : S_HOLD)
            : state == S_HOLD ? S_DONE : S_IDLE;
    bus_request = busy || state == S_REQ;
    as = state == S_ADDR;
    read = state == S_ACC && win_rd;
    write = state == S_ACC && !win_rd;
    write_h = state == S_HOLD;
    address = busy ? s_addr[win] : '0;
    pad_data_out = busy && !win_rd ? s_wdata[win] : '0;
    ch_done = state == S_DONE ? NCH'(1) << win : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pending <= '0;
      rr_ptr <= '0;
      win <= '0;
      cnt <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= state == S_ACC && !last ? cnt + 3'd1 : '0;
      pending <= load | (pending & ~ch_done);
      if (state == S_IDLE && sync && |pick_oh) win <= pick_idx;
      if (state == S_ACC && last && win_rd) rdata <= pad_data_in;
      if (state == S_DONE) rr_ptr <= win == IW'(NCH - 1) ? '0 : win + 1'b1;
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (load[i]) begin
        s_rd[i] <= ch_read[i];
        s_addr[i] <= ch_addr[i*AW +: AW];
        s_wdata[i] <= ch_wdata[i*DW +: DW];
      end
    end
  end
  always_ff @(posedge clk) if (!reset) assert (strobe_ok(as, read, write, write_h));
endmodule

// File: tb/tb_tdsp_mbus_mach.sv
// tb_tdsp_mbus_mach: directed vector table, corner sequences and random traffic against a schedule model
module tb_tdsp_mbus_mach;
  localparam int DW = 16, AW = 8, NCH = 3, W = 2;
  localparam int C_IDLE = 0, C_REQ = 1, C_AS = 2, C_RD = 3, C_WR = 4, C_WH = 5, C_DONE = 6;
  logic clk = 0, reset = 1, sync = 0, bus_grant = 0;
  logic [NCH-1:0] ch_go = '0, ch_read = '0, ch_done;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH*DW-1:0] ch_wdata = '0;
  logic [DW-1:0] rdata, pad_data_out, pad_data_in = '0;
  logic bus_request, as, read, write, write_h;
  logic [AW-1:0] address;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  tdsp_mbus_mach #(.DW(DW), .AW(AW), .NCH(NCH), .WAIT(W)) dut (
    .clk(clk), .reset(reset), .sync(sync), .ch_go(ch_go), .ch_read(ch_read),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_done(ch_done), .rdata(rdata),
    .bus_request(bus_request), .bus_grant(bus_grant), .as(as), .read(read),
    .write(write), .write_h(write_h), .address(address),
    .pad_data_out(pad_data_out), .pad_data_in(pad_data_in));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: pending slots plus a per-transaction list of expected bus phases
  bit m_pend[NCH];
  bit m_rd[NCH];
  logic [AW-1:0] m_addr[NCH];
  logic [DW-1:0] m_wd[NCH];
  int m_rr = 0, m_win = 0, m_cur = C_IDLE;
  logic [DW-1:0] m_rdata = '0, m_cand = '0;
  int m_q[$];

  task automatic model_step();
    int prev, dch;
    bit act;
    prev = m_cur;
    if (reset) begin
      m_pend = '{default: 0};
      m_rr = 0;
      m_cur = C_IDLE;
      m_rdata = '0;
      m_q.delete();
    end else begin
      dch = prev == C_DONE ? m_win : -1;
      if (prev == C_RD) m_cand = pad_data_in;
      if (prev == C_DONE) m_rr = (m_win + 1) % NCH;
      if (prev == C_IDLE) begin
        if (sync) for (int k = 0; k < NCH; k++)
          if (m_cur == C_IDLE && m_pend[(m_rr + k) % NCH]) begin
            m_win = (m_rr + k) % NCH;
            m_cur = C_REQ;
          end
      end else if (prev == C_REQ) begin
        if (bus_grant) begin
          m_q.delete();
          for (int k = 0; k <= W; k++) m_q.push_back(m_rd[m_win] ? C_RD : C_WR);
          if (!m_rd[m_win]) m_q.push_back(C_WH);
          m_q.push_back(C_DONE);
          m_cur = C_AS;
        end
      end else m_cur = m_q.size() > 0 ? m_q.pop_front() : C_IDLE;
      for (int i = 0; i < NCH; i++) begin
        if (ch_go[i] && (!m_pend[i] || dch == i)) begin
          m_pend[i] = 1;
          m_rd[i] = ch_read[i];
          m_addr[i] = ch_addr[i*AW +: AW];
          m_wd[i] = ch_wdata[i*DW +: DW];
        end else if (dch == i) m_pend[i] = 0;
      end
      if (m_cur == C_DONE && m_rd[m_win]) m_rdata = m_cand;
    end
    act = m_cur inside {C_AS, C_RD, C_WR, C_WH};
    chk("strobes", {bus_request, as, read, write, write_h},
        {m_cur == C_REQ || act, m_cur == C_AS, m_cur == C_RD, m_cur == C_WR, m_cur == C_WH});
    chk("one_strobe", $countones({as, read, write, write_h}) <= 1, 1);
    chk("address", address, act ? m_addr[m_win] : '0);
    chk("pad_data_out", pad_data_out, act && !m_rd[m_win] ? m_wd[m_win] : '0);
    chk("ch_done", ch_done, m_cur == C_DONE ? NCH'(1) << m_win : '0);
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  typedef struct {
    int ch; bit rd; logic [AW-1:0] a; logic [DW-1:0] wd; logic [DW-1:0] pad; int gd;
  } vec_t;
  vec_t tv[6];

  task automatic run_vec(input vec_t v);
    int got, nr, nw, nh;
    bit seen_as;
    got = -1; nr = 0; nw = 0; nh = 0; seen_as = 0;
    ch_go = '0;
    ch_go[v.ch] = 1;
    ch_read[v.ch] = v.rd;
    ch_addr[v.ch*AW +: AW] = v.a;
    ch_wdata[v.ch*DW +: DW] = v.wd;
    pad_data_in = v.pad;
    bus_grant = 0;
    for (int n = 1; n <= 40 && got < 0; n++) begin
      tick();
      ch_go = '0;
      if (as) begin
        seen_as = 1;
        chk("vec_address", address, v.a);
      end
      nr += int'(read); nw += int'(write); nh += int'(write_h);
      if (ch_done[v.ch]) got = n;
      bus_grant = !seen_as && n >= 2 + v.gd;
    end
    chk("latency", got, (v.rd ? 5 : 6) + W + v.gd);
    chk("access_cycles", v.rd ? nr : nw, W + 1);
    chk("other_access", v.rd ? nw : nr, 0);
    chk("write_h_cycles", nh, v.rd ? 0 : 1);
    if (v.rd) last_rd = v.pad;
    chk("vec_rdata", rdata, last_rd);
    tick();
    tick();
  endtask

  initial begin
    int k, st, nd, got;
    int ord[3];
    tv = '{'{0, 1, 8'h12, 16'h0000, 16'hBEEF, 0},
           '{2, 0, 8'h40, 16'h1234, 16'h0000, 0},
           '{1, 1, 8'hFF, 16'h0000, 16'h0001, 10},
           '{1, 0, 8'h00, 16'hFFFF, 16'h0000, 3},
           '{0, 0, 8'h7F, 16'h8000, 16'hAAAA, 0},
           '{2, 1, 8'h80, 16'h0000, 16'h5A5A, 1}};
    repeat (3) tick();
    chk("reset_rdata", rdata, 0);
    reset = 0;
    sync = 1;
    tick();
    foreach (tv[e]) run_vec(tv[e]);

    // simultaneous bursts from rr_ptr=0
    reset = 1; tick(); reset = 0;
    bus_grant = 1;
    for (int b = 0; b < 2; b++) begin
      ch_go = '1;
      ch_read = 3'b010;
      ch_addr = {8'h23, 8'h22, 8'h21};
      ch_wdata = {16'h3333, 16'h2222, 16'h1111};
      tick();
      ch_go = '0;
      k = 0;
      for (int n = 0; n < 60 && k < 3; n++) begin
        tick();
        if (|ch_done && k < 3) begin
          ord[k] = ch_done[0] ? 0 : ch_done[1] ? 1 : 2;
          k++;
        end
      end
      chk("burst_count", k, 3);
      for (int i = 0; i < 3; i++) chk($sformatf("burst%0d_order%0d", b, i), ord[i], i);
    end
    tick();

    // go held while pending is ignored; go during ch_done re-arms with new values
    ch_go = 3'b010; ch_read[1] = 1; ch_addr[AW +: AW] = 8'h11;
    tick();
    ch_addr[AW +: AW] = 8'h33;
    st = 0;
    for (int n = 0; n < 80 && st < 4; n++) begin
      tick();
      if (st == 0 && as) begin chk("first_addr", address, 8'h11); st = 1; end
      else if (st == 1 && ch_done[1]) begin ch_addr[AW +: AW] = 8'h55; st = 2; end
      else if (st == 2) begin ch_go = '0; st = 3; end
      else if (st == 3 && as) begin chk("rearm_addr", address, 8'h55); st = 4; end
    end
    ch_go = '0;
    chk("rearm_reached", st, 4);
    nd = 0;
    for (int n = 0; n < 20; n++) begin tick(); nd += int'(ch_done[1]); end
    chk("rearm_done_once", nd, 1);

    // reset in the middle of a write access
    ch_go = 3'b001; ch_read[0] = 0; ch_addr[0 +: AW] = 8'hA5; ch_wdata[0 +: DW] = 16'hC3C3;
    tick();
    ch_go = '0;
    for (int n = 0; n < 20 && !write; n++) tick();
    chk("reached_acc", write, 1);
    reset = 1; tick(); reset = 0;
    chk("reset_outputs", {ch_done, bus_request, as, read, write, write_h, address, pad_data_out, rdata}, 0);
    nd = 0;
    repeat (8) begin tick(); nd += int'(|ch_done); end
    chk("no_done_after_reset", nd, 0);
    ch_go = 3'b100; ch_read[2] = 1; ch_addr[2*AW +: AW] = 8'h9C; pad_data_in = 16'h7E57;
    tick();
    ch_go = '0;
    got = -1;
    for (int n = 2; n < 40 && got < 0; n++) begin tick(); if (ch_done[2]) got = n; end
    chk("post_reset_latency", got, 5 + W);
    chk("post_reset_rdata", rdata, 16'h7E57);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      sync = $urandom_range(0, 3) != 0;
      bus_grant = $urandom_range(0, 2) != 0;
      pad_data_in = DW'($urandom);
      for (int i = 0; i < NCH; i++) begin
        ch_go[i] = $urandom_range(0, 5) == 0;
        ch_read[i] = 1'($urandom);
        ch_addr[i*AW +: AW] = AW'($urandom);
        ch_wdata[i*DW +: DW] = DW'($urandom);
      end
      tick();
    end
    ch_go = '0; sync = 1; bus_grant = 1;
    repeat (60) tick();
    chk("drained_idle", bus_request, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule

// File: doc/tdsp_mbus_mach.md
TDSP_MBUS_MACH -- requirements
Module: tdsp_mbus_mach

Interface
REQ-001 Parameter DW, default 16: data width of all data paths.
REQ-002 Parameter AW, default 8: address width.
REQ-003 Parameter NCH, default 3, range 1..8: number of requesting channels.
REQ-004 Parameter WAIT, default 0, range 0..7: wait states added to each access phase.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sync  in  1  phase strobe, equivalent to phi_6; a new bus cycle may start only while sync is high.
REQ-008 ch_go  in  NCH  per-channel request pulse.
REQ-009 ch_read  in  NCH  per-channel cycle type, sampled with ch_go: 1 = read, 0 = write.
REQ-010 ch_addr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
REQ-011 ch_wdata  in  NCH*DW  per-channel write data, same packing as ch_addr.
REQ-012 ch_done  out  NCH  one-cycle completion pulse per channel.
REQ-013 rdata  out  DW  last read data returned; held until the next read completes.
REQ-014 bus_request  out  1; bus_grant  in  1  external bus ownership handshake.
REQ-015 as, read, write, write_h  out  1 each  bus strobes.
REQ-016 address  out  AW; pad_data_out  out  DW; pad_data_in  in  DW  external bus.

Function
REQ-017 ch_go[i] high SHALL set pending[i] and latch ch_read[i], ch_addr[i] and ch_wdata[i] into that channel's slot on the same edge.
REQ-018 While pending[i] is set, ch_go[i] SHALL be ignored (no overwrite), except in the cycle that ch_done[i] pulses, when it re-arms pending[i] with the new values.
REQ-019 FSM states are IDLE, REQ, ADDR, ACC, HOLD, DONE.
REQ-020 IDLE: when sync=1 and any pending bit is set, the FSM SHALL select a winner round-robin, starting at rr_ptr and searching upward with wrap, then go to REQ; otherwise it SHALL stay in IDLE.
REQ-021 REQ: bus_request=1; when bus_grant=1, go to ADDR; otherwise wait indefinitely.
REQ-022 bus_request SHALL stay high from REQ through HOLD and drop in DONE.
REQ-023 ADDR: as=1 for 1 cycle, then go to ACC.
REQ-024 address SHALL be driven with the winner's address from ADDR through HOLD, and SHALL be 0 otherwise.
REQ-025 ACC: read=1 (read cycle) or write=1 (write cycle) for exactly WAIT+1 cycles.
REQ-026 Read: rdata SHALL capture pad_data_in on the last ACC cycle; the FSM then goes to DONE.
REQ-027 Write: pad_data_out SHALL equal the winner's wdata from ADDR through HOLD, and 0 otherwise; after ACC the FSM goes to HOLD, where write_h=1 for 1 cycle, then to DONE.
REQ-028 DONE: ch_done[winner]=1 for 1 cycle; pending[winner] is cleared unless re-armed per REQ-018; rr_ptr = (winner+1) mod NCH; next state IDLE.
REQ-029 Deassertion of bus_grant after ADDR SHALL be ignored: the cycle completes.
REQ-030 At most one strobe of as, read, write, write_h SHALL be high in any cycle.
REQ-031 Read latency, ideal case (go at cycle t, sync=1 at t+1, immediate grant, WAIT=0): ch_done at t+5.
REQ-032 Write latency, same conditions: ch_done at t+6.

Reset
REQ-033 reset=1 SHALL, on the next edge, force IDLE, clear pending, set rr_ptr=0, and zero all outputs including rdata; this holds mid-cycle and no ch_done is issued for an aborted cycle.

Structure
REQ-034 State encoding, the default parameter values and the strobe-exclusivity rule belong in the shared tdsp package/header with the other tdsp defines.
REQ-035 Round-robin winner selection SHALL be one combinational sub-module, tdsp_rr_pick (inputs: pending and rr_ptr; outputs: one-hot winner and its index).
REQ-036 Intended use is to replace the separate program, data and port bus machines with one instance of NCH=3.

Verification
REQ-037 Single read, ch0, addr 0x12, pad_data_in=0xBEEF, WAIT=0, grant tied high -> as at t+3, read at t+4, ch_done[0] at t+5, rdata=0xBEEF.
REQ-038 Single write, ch2, addr 0x40, wdata 0x1234, WAIT=2 -> write high 3 cycles, write_h 1 cycle, address=0x40 and pad_data_out=0x1234 throughout, ch_done[2] once.
REQ-039 ch0, ch1, ch2 go together, rr_ptr=0 -> service order 0, 1, 2; a second simultaneous burst is served 0, 1, 2 again; no ch_done overlap.
REQ-040 Grant withheld 10 cycles -> bus_request high, no strobes; grant at cycle 11 -> as next cycle; grant dropped during ACC -> cycle still completes.
REQ-041 reset asserted during ACC of a write -> next cycle all outputs 0, no ch_done, pending=0; new go afterwards is served normally.
REQ-042 ch1 go in the same cycle as ch_done[1] with addr 0x55 -> second ch1 cycle uses 0x55; a go while pending is ignored.
